sp_stream_tx: RTL and testbench
===============================

# sp_stream_tx

Scratchpad-side transmitter feeding the systolic array's input controller. It accepts a tile command naming a block of activation words and a block of weight words in scratchpad SRAM. It fetches them through a single shared read port and presents them one 64-bit word at a time on the din channel (sp_din_out/sp_load) and the weight channel (sp_wt_out/sp_load2). Each word is signalled with a strobe pulse that the controller edge-detects.

## Interface
Parameters:
- ADDR_W, 10, scratchpad word-address width
- LEN_W, 8, word-count width per channel
- HOLD, 2, strobe-high cycles per word (≥1)
- GAP, 2, strobe-low cycles after each word (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only when both channels idle
- cmd_din_base  in  ADDR_W  first din word address
- cmd_din_len  in  LEN_W  din word count (0 = skip channel)
- cmd_wt_base  in  ADDR_W  first weight word address
- cmd_wt_len  in  LEN_W  weight word count (0 = skip channel)
- mem_req  out  1  read request, one per cycle max
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  64  read data, valid exactly 1 cycle after mem_req
- sp_din_out  out  64  din word
- sp_load  out  1  din strobe
- sp_wt_out  out  64  weight word
- sp_load2  out  1  weight strobe
- isNewDin, isNewWtin  in  1 each  group-complete toggles from controller (used only with SP_TX_ACK_EN)
- busy  out  1  any channel active
- done  out  1  one-cycle pulse when command completes

## Operation
- Command is accepted on a cycle with cmd_valid & cmd_ready. Both channels load base/len, and each channel with len≠0 leaves IDLE.
- Per-channel FSM: IDLE → FETCH (assert request, hold until granted) → WAIT (memory latency) → SETUP (rdata registered onto sp_*_out, strobe low) → HIGH (strobe=1, HOLD cycles) → LOW (strobe=0, GAP cycles) → FETCH if words remain, else IDLE. With SP_TX_ACK_EN, an ACKWAIT state may be inserted after LOW (see Configuration).
- Word address = base + index, wrapping modulo 2^ADDR_W. Index counts 0..len-1.
- Arbitration: round-robin on mem port. On simultaneous FETCH, grant goes to the channel not granted last; after reset din has priority. A loser stays in FETCH.
- sp_*_out holds its value from SETUP until the next SETUP of that channel, so data is stable through the controller's edge-detect-plus-one-cycle capture.
- done pulses the cycle after the last active channel returns to IDLE. A command with both lens 0 gives done the cycle after acceptance.
- Reset mid-operation: on the next edge both FSMs go to IDLE, strobes drop low and counters clear. A partially sent word is abandoned.

## Timing
- Reset values: cmd_ready=1, mem_req=0, mem_addr=0, sp_din_out=0, sp_wt_out=0, sp_load=0, sp_load2=0, busy=0, done=0; the internal RR pointer selects din.
- Uncontended single channel: command at cycle 0, mem_req cycle 1, SETUP cycle 3, strobe high cycles 4..3+HOLD, low for GAP cycles, next mem_req at cycle 4+HOLD+GAP. Word period is 3+HOLD+GAP cycles (7 by default).
- Contention adds exactly one FETCH cycle to the losing channel per conflict.
- busy=1 from the cycle after acceptance through the last LOW/ACKWAIT cycle. cmd_ready = ~busy.

## Configuration
- SP_TX_ACK_EN defined: each channel samples its isNew* input at command acceptance. After every complete group (4 words din, 16 words weight) it enters ACKWAIT until the input toggles relative to the last sampled value, then continues. A trailing partial group never waits.
- Undefined: no ACKWAIT state, the isNew* inputs are ignored, and channels free-run at the word period.

## Structure
- Package sp_tx_pkg: channel-state enum, GROUP_DIN=4, GROUP_WT=16, default HOLD/GAP.
- Sub-module sp_tx_channel (FSM, address/count, output register, optional ACKWAIT), instantiated twice. The arbiter and done logic live in the top level.

## Test plan
- din_len=4, wt_len=0, base=0x3FE: mem_addr sequence 0x3FE,0x3FF,0x000,0x001. Exactly 4 sp_load rising edges 7 cycles apart. done 1 cycle after the final LOW.
- din_len=4, wt_len=16 simultaneous: first grants alternate din, wt, din, … Each loser incurs a 1-cycle delay. Total 20 strobe edges with correct data per address.
- Memory model returns address as data: each sp_*_out value equals its word address during HIGH and the following cycle.
- Reset asserted during a din HIGH: next cycle sp_load=0, busy=0, cmd_ready=1. A new command restarts from its base.
- SP_TX_ACK_EN, din_len=8, isNewDin held constant: 4 words sent, then stall. Toggling isNewDin releases words 5–8, and done follows with no further wait.
- Both lens 0: done pulses the cycle after acceptance, and mem_req is never asserted.

Source files
------------

// File: rtl/sp_tx_pkg.sv
// -----------------------------------------------------------------------------
// sp_tx_pkg
// Shared definitions for the scratchpad stream transmitter (sp_stream_tx).
//   ch_state_e   - per-channel FSM state encoding
//   GROUP_DIN    - din words per acknowledged group (SP_TX_ACK_EN builds)
//   GROUP_WT     - weight words per acknowledged group (SP_TX_ACK_EN builds)
//   DEFAULT_HOLD - default strobe-high cycles per word
//   DEFAULT_GAP  - default strobe-low cycles after each word
//   cnt_width()  - width of the HOLD/GAP phase counter
// -----------------------------------------------------------------------------
package sp_tx_pkg;

  // Explicit encodings keep the state values stable for anyone probing the
  // design from older tools or waveform scripts.
  typedef enum logic [2:0] {
    CH_IDLE    = 3'd0,
    CH_FETCH   = 3'd1,
    CH_WAIT    = 3'd2,
    CH_SETUP   = 3'd3,
    CH_HIGH    = 3'd4,
    CH_LOW     = 3'd5,
    CH_ACKWAIT = 3'd6
  } ch_state_e;

  localparam int GROUP_DIN    = 4;
  localparam int GROUP_WT     = 16;
  localparam int DEFAULT_HOLD = 2;
  localparam int DEFAULT_GAP  = 2;

  // The phase counter is loaded with HOLD-1 or GAP-1 and counts down to zero,
  // so it must represent max(HOLD,GAP)-1.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sp_tx_channel.sv
// -----------------------------------------------------------------------------
// sp_tx_channel
// One transmit channel: walks a block of scratchpad words, fetching each one
// through the shared read port and presenting it with a HOLD-cycle strobe
// followed by a GAP-cycle quiet period.
//
// Optional feature: define SP_TX_ACK_EN to stall after every complete group of
// GROUP words until ack_i toggles relative to the value last sampled.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start_i     - command accepted this cycle (loads base/len)
//   base_i      - first word address
//   len_i       - word count (0 = channel stays idle)
//   grant_i     - arbiter grant for this channel's request
//   rdata_i     - scratchpad read data (valid the cycle after the grant)
//   ack_i       - group-complete toggle from the controller
//   req_o       - read request (channel in FETCH)
//   addr_o      - read address of the current word
//   data_o      - registered word presented to the controller
//   strobe_o    - word strobe
//   busy_o      - channel not idle
//   idle_next_o - channel will be idle next cycle
// -----------------------------------------------------------------------------
module sp_tx_channel
  import sp_tx_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int HOLD   = DEFAULT_HOLD,
  parameter int GAP    = DEFAULT_GAP,
  parameter int GROUP  = GROUP_DIN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              grant_i,
  input  logic [63:0]       rdata_i,
  input  logic              ack_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [63:0]       data_o,
  output logic              strobe_o,
  output logic              busy_o,
  output logic              idle_next_o
);

  localparam int CNT_W = cnt_width(HOLD, GAP);

  ch_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;   // address of the next word to fetch
  logic [LEN_W-1:0]  rem_q, rem_d;     // words not yet fetched
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // cycles left in HIGH/LOW
  logic [63:0]       data_q, data_d;

`ifdef SP_TX_ACK_EN
  localparam int GROUP_W = (GROUP > 2) ? $clog2(GROUP) : 1;

  logic [GROUP_W-1:0] grp_q, grp_d;    // completed words within current group
  logic               ack_ref_q, ack_ref_d;
`else
  localparam int unused_group = GROUP;
  logic unused_ack;
  assign unused_ack = ack_i;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef SP_TX_ACK_EN
    grp_d     = grp_q;
    ack_ref_d = ack_ref_q;
`endif

    unique case (state_q)
      CH_IDLE: begin
        if (start_i) begin
`ifdef SP_TX_ACK_EN
          // Reference level for the toggle handshake is taken at acceptance.
          ack_ref_d = ack_i;
          grp_d     = '0;
`endif
          if (len_i != '0) begin
            state_d = CH_FETCH;
            addr_d  = base_i;
            rem_d   = len_i;
          end
        end
      end

      // Request is held until the arbiter grants it.
      CH_FETCH: begin
        if (grant_i) state_d = CH_WAIT;
      end

      // Read data arrives this cycle; capture it and advance to the next word.
      // The address wraps naturally at 2^ADDR_W.
      CH_WAIT: begin
        data_d  = rdata_i;
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - LEN_W'(1);
        state_d = CH_SETUP;
      end

      // Data is stable on the output one cycle before the strobe rises.
      CH_SETUP: begin
        state_d = CH_HIGH;
        cnt_d   = CNT_W'(HOLD - 1);
      end

      CH_HIGH: begin
        if (cnt_q == '0) begin
          state_d = CH_LOW;
          cnt_d   = CNT_W'(GAP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      CH_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rem_q == '0) begin
          // Last word of the block never waits for an acknowledge.
          state_d = CH_IDLE;
        end else begin
`ifdef SP_TX_ACK_EN
          if (grp_q == GROUP_W'(GROUP - 1)) begin
            grp_d   = '0;
            state_d = CH_ACKWAIT;
          end else begin
            grp_d   = grp_q + GROUP_W'(1);
            state_d = CH_FETCH;
          end
`else
          state_d = CH_FETCH;
`endif
        end
      end

`ifdef SP_TX_ACK_EN
      // Controller signals group consumption by toggling its flag.
      CH_ACKWAIT: begin
        if (ack_i != ack_ref_q) begin
          ack_ref_d = ack_i;
          state_d   = CH_FETCH;
        end
      end
`endif

      default: state_d = CH_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      // NOTE: the data register is reset as well because it drives a module
      // output whose post-reset value is defined as zero.
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef SP_TX_ACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grp_q     <= '0;
      ack_ref_q <= 1'b0;
    end else begin
      grp_q     <= grp_d;
      ack_ref_q <= ack_ref_d;
    end
  end
`endif

  assign req_o       = (state_q == CH_FETCH);
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign strobe_o    = (state_q == CH_HIGH);
  assign busy_o      = (state_q != CH_IDLE);
  assign idle_next_o = (state_d == CH_IDLE);

endmodule

// File: rtl/sp_stream_tx.sv
// -----------------------------------------------------------------------------
// sp_stream_tx
// Scratchpad-side transmitter for the systolic array input controller. A tile
// command names a block of activation (din) words and a block of weight
// words; both are fetched through one shared scratchpad read port and handed
// over one 64-bit word at a time, each marked by a strobe pulse.
//
// Optional feature: define SP_TX_ACK_EN to make each channel pause after every
// complete group (4 din / 16 weight words) until the matching isNew* input
// toggles. Without it the isNew* inputs are ignored.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   cmd_valid/ready   - command handshake (ready only while fully idle)
//   cmd_din_base/len  - din block address and word count
//   cmd_wt_base/len   - weight block address and word count
//   mem_req/addr      - shared scratchpad read request
//   mem_rdata         - read data, one cycle after mem_req
//   sp_din_out/load   - din word and strobe
//   sp_wt_out/load2   - weight word and strobe
//   isNewDin/WtIn     - group-complete toggles from the controller
//   busy              - any channel active
//   done              - one-cycle pulse when the command completes
// -----------------------------------------------------------------------------
module sp_stream_tx
  import sp_tx_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int HOLD   = DEFAULT_HOLD,
  parameter int GAP    = DEFAULT_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_din_base,
  input  logic [LEN_W-1:0]  cmd_din_len,
  input  logic [ADDR_W-1:0] cmd_wt_base,
  input  logic [LEN_W-1:0]  cmd_wt_len,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rdata,
  output logic [63:0]       sp_din_out,
  output logic              sp_load,
  output logic [63:0]       sp_wt_out,
  output logic              sp_load2,
  input  logic              isNewDin,
  input  logic              isNewWtin,
  output logic              busy,
  output logic              done
);

  logic              accept;
  logic              din_req, wt_req;
  logic              din_gnt, wt_gnt;
  logic [ADDR_W-1:0] din_addr, wt_addr;
  logic              din_busy, wt_busy;
  logic              din_idle_next, wt_idle_next;
  logic              din_ack, wt_ack;
  logic              din_prio_q;      // 1: din wins the next conflict
  logic              done_q;

  assign accept = cmd_valid & cmd_ready;

`ifdef SP_TX_ACK_EN
  assign din_ack = isNewDin;
  assign wt_ack  = isNewWtin;
`else
  logic unused_isnew;
  assign unused_isnew = isNewDin ^ isNewWtin;
  assign din_ack      = 1'b0;
  assign wt_ack       = 1'b0;
`endif

  sp_tx_channel #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .HOLD   (HOLD),
    .GAP    (GAP),
    .GROUP  (GROUP_DIN)
  ) u_din (
    .clk         (clk),
    .reset       (reset),
    .start_i     (accept),
    .base_i      (cmd_din_base),
    .len_i       (cmd_din_len),
    .grant_i     (din_gnt),
    .rdata_i     (mem_rdata),
    .ack_i       (din_ack),
    .req_o       (din_req),
    .addr_o      (din_addr),
    .data_o      (sp_din_out),
    .strobe_o    (sp_load),
    .busy_o      (din_busy),
    .idle_next_o (din_idle_next)
  );

  sp_tx_channel #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .HOLD   (HOLD),
    .GAP    (GAP),
    .GROUP  (GROUP_WT)
  ) u_wt (
    .clk         (clk),
    .reset       (reset),
    .start_i     (accept),
    .base_i      (cmd_wt_base),
    .len_i       (cmd_wt_len),
    .grant_i     (wt_gnt),
    .rdata_i     (mem_rdata),
    .ack_i       (wt_ack),
    .req_o       (wt_req),
    .addr_o      (wt_addr),
    .data_o      (sp_wt_out),
    .strobe_o    (sp_load2),
    .busy_o      (wt_busy),
    .idle_next_o (wt_idle_next)
  );

  // Round-robin between two requesters: a lone request is always granted, a
  // conflict goes to whichever channel was not granted most recently.
  assign din_gnt = din_req & (~wt_req | din_prio_q);
  assign wt_gnt  = wt_req & ~din_gnt;

  assign mem_req  = din_req | wt_req;
  assign mem_addr = din_gnt ? din_addr :
                    wt_gnt  ? wt_addr  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      din_prio_q <= 1'b1;
    end else if (din_gnt) begin
      din_prio_q <= 1'b0;
    end else if (wt_gnt) begin
      din_prio_q <= 1'b1;
    end
  end

  // done marks the first fully idle cycle after a command: either the cycle
  // after an empty command is accepted, or the cycle after the last active
  // channel leaves its final LOW/ACKWAIT state.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (accept && cmd_din_len == '0 && cmd_wt_len == '0) ||
                ((din_busy | wt_busy) && din_idle_next && wt_idle_next);
    end
  end

  assign busy      = din_busy | wt_busy;
  assign cmd_ready = ~busy;
  assign done      = done_q;

endmodule

// File: tb/tb_sp_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_sp_stream_tx
// Self-checking bench for sp_stream_tx. The memory returns each word's address
// as its data. A word-level reference model predicts, per command, the cycle
// and address of every grant, every strobe rising edge with its data, and the
// done cycle; a negedge monitor records what the design actually did.
// -----------------------------------------------------------------------------
module tb_sp_stream_tx;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int HOLD   = 2;
  localparam int GAP    = 2;
  localparam int PERIOD = 3 + HOLD + GAP;

  typedef struct {
    int              cyc;
    logic [ADDR_W-1:0] addr;
  } req_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    int          run;
    bit          stable;
  } edge_t;

  typedef struct {
    logic [ADDR_W-1:0] db;
    int                dl;
    logic [ADDR_W-1:0] wb;
    int                wl;
    int                exp_reqs;
    int                exp_done_off;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_din_base, cmd_wt_base;
  logic [LEN_W-1:0]  cmd_din_len, cmd_wt_len;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_rdata;
  logic [63:0]       sp_din_out, sp_wt_out;
  logic              sp_load, sp_load2;
  logic              isNewDin, isNewWtin;
  logic              busy, done;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit     mon_en = 0;
  req_t   act_req_q[$], exp_req_q[$];
  edge_t  act_din_q[$], act_wt_q[$], exp_din_q[$], exp_wt_q[$];
  int     act_done_q[$];
  int     exp_done;
  bit     m_din_prio;   // model: din wins the next tie

  bit    d_hi, w_hi;
  edge_t d_cur, w_cur;

  sp_stream_tx #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .HOLD   (HOLD),
    .GAP    (GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_din_base (cmd_din_base),
    .cmd_din_len  (cmd_din_len),
    .cmd_wt_base  (cmd_wt_base),
    .cmd_wt_len   (cmd_wt_len),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .sp_din_out   (sp_din_out),
    .sp_load      (sp_load),
    .sp_wt_out    (sp_wt_out),
    .sp_load2     (sp_load2),
    .isNewDin     (isNewDin),
    .isNewWtin    (isNewWtin),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scratchpad: one-cycle read latency, data = zero-extended address.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= {{(64-ADDR_W){1'b0}}, mem_addr};
    else         mem_rdata <= {$urandom, $urandom};
  end

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!mon_en) begin
      d_hi = 0;
      w_hi = 0;
    end else begin
      if (mem_req) act_req_q.push_back('{cyc, mem_addr});
      if (done) act_done_q.push_back(cyc);
      if (sp_load) begin
        if (!d_hi) begin
          d_hi = 1;
          d_cur = '{cyc, sp_din_out, 1, 1'b1};
        end else begin
          d_cur.run++;
          if (sp_din_out !== d_cur.data) d_cur.stable = 0;
        end
      end else if (d_hi) begin
        d_hi = 0;
        if (sp_din_out !== d_cur.data) d_cur.stable = 0;
        act_din_q.push_back(d_cur);
      end
      if (sp_load2) begin
        if (!w_hi) begin
          w_hi = 1;
          w_cur = '{cyc, sp_wt_out, 1, 1'b1};
        end else begin
          w_cur.run++;
          if (sp_wt_out !== w_cur.data) w_cur.stable = 0;
        end
      end else if (w_hi) begin
        w_hi = 0;
        if (sp_wt_out !== w_cur.data) w_cur.stable = 0;
        act_wt_q.push_back(w_cur);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word-level reference: each channel is ready to fetch at some cycle; the
  // earliest ready channel is granted (ties go to the channel not granted
  // last). A granted word strobes 3 cycles later and the channel is ready
  // again one word period after the grant; a tied loser retries next cycle.
  task automatic build_expect(input logic [ADDR_W-1:0] db, input int dl,
                              input logic [ADDR_W-1:0] wb, input int wl,
                              input int acc);
    int t[2];
    int left[2];
    int idx[2];
    logic [ADDR_W-1:0] base[2];
    logic [ADDR_W-1:0] a;
    int c, g;
    exp_req_q.delete();
    exp_din_q.delete();
    exp_wt_q.delete();
    t[0] = acc + 1;  t[1] = acc + 1;
    left[0] = dl;    left[1] = wl;
    idx[0] = 0;      idx[1] = 0;
    base[0] = db;    base[1] = wb;
    exp_done = acc + 1;
    while (left[0] > 0 || left[1] > 0) begin
      if (left[0] == 0)      c = 1;
      else if (left[1] == 0) c = 0;
      else if (t[0] < t[1])  c = 0;
      else if (t[1] < t[0])  c = 1;
      else                   c = m_din_prio ? 0 : 1;
      g = t[c];
      a = base[c] + ADDR_W'(idx[c]);
      exp_req_q.push_back('{g, a});
      if (c == 0) exp_din_q.push_back('{g + 3, {{(64-ADDR_W){1'b0}}, a}, HOLD, 1'b1});
      else        exp_wt_q.push_back('{g + 3, {{(64-ADDR_W){1'b0}}, a}, HOLD, 1'b1});
      idx[c]++;
      left[c]--;
      m_din_prio = (c == 1);
      t[c] = g + PERIOD;
      if (left[1-c] > 0 && t[1-c] == g) t[1-c] = g + 1;
      if (left[c] == 0 && g + PERIOD > exp_done) exp_done = g + PERIOD;
    end
  endtask

  task automatic clear_mon();
    act_req_q.delete();
    act_din_q.delete();
    act_wt_q.delete();
    act_done_q.delete();
    mon_en = 1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] db, input int dl,
                       input logic [ADDR_W-1:0] wb, input int wl,
                       output int acc);
    int k = 0;
    while (!cmd_ready && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    cmd_din_base = db;
    cmd_din_len  = LEN_W'(dl);
    cmd_wt_base  = wb;
    cmd_wt_len   = LEN_W'(wl);
    cmd_valid    = 1'b1;
    acc          = cyc;
    @(posedge clk); #1;
    cmd_valid    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (act_done_q.size() == 0 && k < 800) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " done_seen"}, 64'(act_done_q.size() != 0), 64'd1);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare_run(input string tag);
    int n;
    check({tag, " req_count"}, 64'(act_req_q.size()), 64'(exp_req_q.size()));
    n = (act_req_q.size() < exp_req_q.size()) ? act_req_q.size() : exp_req_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s req%0d cyc/addr", tag, i),
            {32'(act_req_q[i].cyc), 22'd0, act_req_q[i].addr},
            {32'(exp_req_q[i].cyc), 22'd0, exp_req_q[i].addr});
    check({tag, " din_edges"}, 64'(act_din_q.size()), 64'(exp_din_q.size()));
    n = (act_din_q.size() < exp_din_q.size()) ? act_din_q.size() : exp_din_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s din%0d cyc", tag, i), 64'(act_din_q[i].cyc), 64'(exp_din_q[i].cyc));
      check($sformatf("%s din%0d data", tag, i), act_din_q[i].data, exp_din_q[i].data);
      check($sformatf("%s din%0d hold", tag, i), 64'(act_din_q[i].run), 64'(HOLD));
      check($sformatf("%s din%0d stable", tag, i), 64'(act_din_q[i].stable), 64'd1);
    end
    check({tag, " wt_edges"}, 64'(act_wt_q.size()), 64'(exp_wt_q.size()));
    n = (act_wt_q.size() < exp_wt_q.size()) ? act_wt_q.size() : exp_wt_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s wt%0d cyc", tag, i), 64'(act_wt_q[i].cyc), 64'(exp_wt_q[i].cyc));
      check($sformatf("%s wt%0d data", tag, i), act_wt_q[i].data, exp_wt_q[i].data);
      check($sformatf("%s wt%0d hold", tag, i), 64'(act_wt_q[i].run), 64'(HOLD));
      check($sformatf("%s wt%0d stable", tag, i), 64'(act_wt_q[i].stable), 64'd1);
    end
    check({tag, " done_count"}, 64'(act_done_q.size()), 64'd1);
    if (act_done_q.size() > 0)
      check({tag, " done_cyc"}, 64'(act_done_q[0]), 64'(exp_done));
  endtask

  task automatic run_cmd(input string tag, input logic [ADDR_W-1:0] db, input int dl,
                         input logic [ADDR_W-1:0] wb, input int wl, output int acc);
    clear_mon();
    issue(db, dl, wb, wl, acc);
    build_expect(db, dl, wb, wl, acc);
    wait_done(tag);
    compare_run(tag);
  endtask

  vec_t vecs[5];

  initial begin
    int acc;
    int rmax_din;

    vecs[0] = '{10'h3FE, 4, 10'h100, 16, 20, 114};  // contended, din first
    vecs[1] = '{10'h3FE, 4, 10'h000,  0,  4,  29};  // wrap 0x3FE..0x001
    vecs[2] = '{10'h000, 0, 10'h000,  0,  0,   1};  // empty command
    vecs[3] = '{10'h000, 0, 10'h3FF,  2,  2,  15};  // weight only, wraps
    vecs[4] = '{10'h005, 1, 10'h007,  1,  2,   9};  // one word each

    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_din_base = '0;
    cmd_din_len  = '0;
    cmd_wt_base  = '0;
    cmd_wt_len   = '0;
    isNewDin     = 1'b0;
    isNewWtin    = 1'b0;
    m_din_prio   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    check("rst cmd_ready",  64'(cmd_ready),  64'd1);
    check("rst mem_req",    64'(mem_req),    64'd0);
    check("rst mem_addr",   64'(mem_addr),   64'd0);
    check("rst sp_din_out", sp_din_out,      64'd0);
    check("rst sp_wt_out",  sp_wt_out,       64'd0);
    check("rst sp_load",    64'(sp_load),    64'd0);
    check("rst sp_load2",   64'(sp_load2),   64'd0);
    check("rst busy",       64'(busy),       64'd0);
    check("rst done",       64'(done),       64'd0);

    // Table-driven commands with hand-derived counts and done latency.
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_cmd(tag, vecs[i].db, vecs[i].dl, vecs[i].wb, vecs[i].wl, acc);
      check({tag, " req_total"}, 64'(act_req_q.size()), 64'(vecs[i].exp_reqs));
      if (act_done_q.size() > 0)
        check({tag, " done_off"}, 64'(act_done_q[0] - acc), 64'(vecs[i].exp_done_off));
    end

    // Reset during a din HIGH abandons the word; the next command restarts.
    clear_mon();
    issue(10'h010, 4, 10'h000, 0, acc);
    begin
      int k = 0;
      while (!sp_load && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("rstmid strobe_seen", 64'(sp_load), 64'd1);
    end
    mon_en = 0;
    reset  = 1'b1;
    @(posedge clk); #1;
    check("rstmid sp_load",   64'(sp_load),   64'd0);
    check("rstmid busy",      64'(busy),      64'd0);
    check("rstmid cmd_ready", 64'(cmd_ready), 64'd1);
    check("rstmid mem_req",   64'(mem_req),   64'd0);
    reset      = 1'b0;
    m_din_prio = 1'b1;
    run_cmd("post_rst", 10'h020, 3, 10'h030, 1, acc);

`ifdef SP_TX_ACK_EN
    // Group stall: 4 din words go out, then nothing until isNewDin toggles.
    clear_mon();
    issue(10'h040, 8, 10'h000, 0, acc);
    repeat (60) @(posedge clk);
    #1;
    check("ack stall_edges", 64'(act_din_q.size()), 64'd4);
    check("ack stall_busy",  64'(busy),             64'd1);
    check("ack stall_done",  64'(act_done_q.size()), 64'd0);
    isNewDin = ~isNewDin;
    wait_done("ack");
    check("ack edges", 64'(act_din_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < act_din_q.size(); i++)
      check($sformatf("ack din%0d data", i), act_din_q[i].data, 64'(10'h040 + i));
    if (act_din_q.size() == 8 && act_done_q.size() > 0)
      check("ack done_gap", 64'(act_done_q[0] - act_din_q[7].cyc), 64'(HOLD + GAP));
    m_din_prio = 1'b0;
    rmax_din = 4;
`else
    rmax_din = 6;
`endif

    // Randomised commands against the model.
    for (int i = 0; i < 20; i++) begin
      logic [ADDR_W-1:0] db, wb;
      int dl, wl;
      db = ADDR_W'($urandom);
      wb = ADDR_W'($urandom);
      dl = $urandom_range(rmax_din, 0);
      wl = $urandom_range(6, 0);
      run_cmd($sformatf("rnd%0d", i), db, dl, wb, wl, acc);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
